// File: rtl/cpu_pkg.sv
// Shared CPU definitions: immediate-format encodings, RV32 opcodes, fetch entry
// layout and the opcode predecoder used by fetch.
package cpu_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd7
  } imm_sel_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    imm_sel_t    imm_sel;
  } fetch_entry_t;

  function automatic imm_sel_t predecode(input logic [6:0] opcode);
    imm_sel_t sel;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: sel = IMM_I;
      OP_STORE:                            sel = IMM_S;
      OP_BRANCH:                           sel = IMM_B;
      OP_LUI, OP_AUIPC:                    sel = IMM_U;
      OP_JAL:                              sel = IMM_J;
      default:                             sel = IMM_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, execute redirect and
// the decode-side handshake. master = fetch unit, slave = its environment.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  out_imm_sel;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst, out_imm_sel,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid,
           redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst, out_imm_sel,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid,
           redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO with a clear that overrides push/pop in its cycle.
// Callers guarantee no push when full and no pop when empty.
module fetch_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = bump(wr_q);
      if (pop_i)  rd_d = bump(rd_q);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC owner, request issue with a DEPTH credit limit, in-order
// response buffering with predecode, and redirect flush of in-flight fetches.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = $bits(fetch_entry_t);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] outst, fcount;
  logic [CW+1:0] inflight;
  logic          req_fire, resp_keep, resp_drop, pop, fifo_empty;
  logic [31:0]   issued_pc;
  fetch_entry_t  push_e, head_e;
  logic [EW-1:0] head_raw;

  // Outstanding keepers are exactly the occupancy of the issued-PC queue.
  assign inflight = (CW+2)'(outst) + (CW+2)'(drop_q) + (CW+2)'(fcount);

  assign bus.imem_req_valid = !rst && (inflight < (CW+2)'(DEPTH));
  assign bus.imem_req_addr  = pc_q;

  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign resp_drop = bus.imem_resp_valid && (drop_q != '0);
  assign resp_keep = bus.imem_resp_valid && (drop_q == '0) && !bus.redirect_valid;
  assign pop       = !fifo_empty && bus.out_ready;

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (bus.redirect_valid) begin
      pc_d   = bus.redirect_pc & 32'hFFFF_FFFC;
      // Everything in flight, including a request accepted right now, becomes stale.
      drop_d = drop_q + outst + CW'(req_fire) - CW'(bus.imem_resp_valid);
    end else begin
      if (req_fire)  pc_d   = pc_q + 32'd4;
      if (resp_drop) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC & 32'hFFFF_FFFC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  fetch_fifo #(.W(32), .DEPTH(DEPTH)) u_pcq (
    .clk     (clk),
    .rst     (rst),
    .clear_i (bus.redirect_valid),
    .push_i  (req_fire),
    .pop_i   (resp_keep),
    .din_i   (pc_q),
    .dout_o  (issued_pc),
    .count_o (outst)
  );

  assign push_e = '{pc: issued_pc, inst: bus.imem_resp_data,
                    imm_sel: predecode(bus.imem_resp_data[6:0])};

  fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_entq (
    .clk     (clk),
    .rst     (rst),
    .clear_i (bus.redirect_valid),
    .push_i  (resp_keep),
    .pop_i   (pop),
    .din_i   (push_e),
    .dout_o  (head_raw),
    .count_o (fcount)
  );

  assign head_e     = fetch_entry_t'(head_raw);
  assign fifo_empty = (fcount == '0);

  assign bus.out_valid   = !fifo_empty;
  assign bus.out_pc      = fifo_empty ? 32'h0 : head_e.pc;
  assign bus.out_inst    = fifo_empty ? 32'h0 : head_e.inst;
  assign bus.out_imm_sel = fifo_empty ? 3'd0  : 3'(head_e.imm_sel);
endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: queue-based memory and decode model, directed scenarios with
// literal pins, then randomized traffic with redirects and a mid-run reset.
module tb_fetch_unit;
  localparam int          DEPTH    = 3;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic [2:0] sel; } ent_t;

  mreq_t memq[$];
  ent_t  expq[$];
  int n_chk = 0, n_pass = 0;
  int cyc, epoch, last_due;
  logic [31:0] mpc;
  int rdy_pct, ordy_pct, lat_lo, lat_hi, mem_mode;
  bit ev_fire, ev_outv, ev_pop, ev_resp, ev_rv;
  logic [31:0] ev_addr, ev_pc, ev_inst;
  logic [2:0]  ev_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [2:0] ref_sel(input logic [31:0] d);
    case (d[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: return 3'd0;
      7'h23:                      return 3'd1;
      7'h63:                      return 3'd2;
      7'h37, 7'h17:               return 3'd3;
      7'h6F:                      return 3'd4;
      default:                    return 3'd7;
    endcase
  endfunction

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  op;
    if (mem_mode == 0) return a >> 2;
    if (mem_mode == 1) begin
      case ((a >> 2) % 6)
        0: return 32'h0050_0093;
        1: return 32'h0011_2023;
        2: return 32'h0000_0463;
        3: return 32'h0000_12B7;
        4: return 32'h0080_006F;
        default: return 32'h0020_81B3;
      endcase
    end
    h = a * 32'h9E37_79B1;
    case (h[31:28])
      0: op = 7'h13;  1: op = 7'h03;  2: op = 7'h67;  3: op = 7'h73;
      4: op = 7'h23;  5: op = 7'h63;  6: op = 7'h37;  7: op = 7'h17;
      8: op = 7'h6F;  default: op = h[22:16];
    endcase
    return {h[31:7] ^ a[31:7], op};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.out_ready       = 1'b0;
    memq.delete();
    expq.delete();
    epoch = 0; mpc = RESET_PC & 32'hFFFF_FFFC; last_due = -1; cyc = 0;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'd0);
    chk("rst_out_sel", 32'(bus.out_imm_sel), 32'd0);
    rst = 1'b0;
  endtask

  // One cycle: compare DUT against the model, drive inputs, advance the model.
  task automatic step(input bit rdir, input logic [31:0] rpc);
    bit exp_rv, fire, resp, pop;
    logic [31:0] rdata;
    mreq_t m;
    int pre_sz, lat;
    #1;
    exp_rv = (memq.size() + expq.size()) < DEPTH;
    ev_rv = bus.imem_req_valid; ev_addr = bus.imem_req_addr;
    ev_pc = bus.out_pc; ev_inst = bus.out_inst; ev_sel = bus.out_imm_sel;
    chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", bus.imem_req_addr, mpc);
    chk("out_valid", 32'(bus.out_valid), 32'(expq.size() > 0));
    if (expq.size() > 0) begin
      chk("out_pc", bus.out_pc, expq[0].pc);
      chk("out_inst", bus.out_inst, expq[0].inst);
      chk("out_sel", 32'(bus.out_imm_sel), 32'(expq[0].sel));
    end

    bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
    bus.out_ready      = ($urandom_range(99) < ordy_pct);
    resp = 1'b0;
    if (memq.size() > 0) resp = (memq[0].due <= cyc);
    rdata = $urandom;
    if (resp) rdata = mem_data(memq[0].addr);
    bus.imem_resp_valid = resp;
    bus.imem_resp_data  = rdata;
    bus.redirect_valid  = rdir;
    bus.redirect_pc     = rdir ? rpc : $urandom;

    fire = exp_rv && bus.imem_req_ready;
    pop  = (expq.size() > 0) && bus.out_ready;
    ev_fire = fire; ev_outv = expq.size() > 0; ev_pop = pop; ev_resp = resp;

    pre_sz = expq.size();
    if (pop) void'(expq.pop_front());
    if (resp) begin
      m = memq.pop_front();
      if (m.epoch == epoch && !rdir) begin
        chk("fifo_room", 32'(pre_sz < DEPTH), 32'd1);
        expq.push_back('{pc: m.addr, inst: rdata, sel: ref_sel(rdata)});
      end
    end
    if (fire) begin
      lat = int'($urandom_range(lat_hi, lat_lo));
      m.addr = mpc; m.due = cyc + lat; m.epoch = epoch;
      if (m.due <= last_due) m.due = last_due + 1;
      last_due = m.due;
      memq.push_back(m);
      mpc = mpc + 32'd4;
    end
    if (rdir) begin
      epoch++;
      expq.delete();
      mpc = rpc & 32'hFFFF_FFFC;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int first, nout, gaps, acc, found, lat_n, na;
    logic [31:0] wa [2];
    logic [2:0]  psel [6];
    psel = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};

    // Streaming at L=1: PCs 0,4,8,... with no bubbles after the first output.
    rdy_pct = 100; ordy_pct = 100; lat_lo = 1; lat_hi = 1; mem_mode = 0;
    do_reset();
    first = -1; nout = 0; gaps = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 32'h0);
      if (ev_outv) begin
        if (first < 0) first = k;
        chk("p1_pc", ev_pc, 32'(nout * 4));
        chk("p1_inst", ev_inst, 32'(nout));
        nout++;
      end else if (first >= 0) gaps++;
    end
    chk("p1_first_out", 32'(first), 32'd2);
    chk("p1_gaps", 32'(gaps), 32'd0);

    // Back-pressure: exactly DEPTH accepts, request drops, then in-order drain.
    ordy_pct = 0;
    do_reset();
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 32'h0);
      if (ev_fire) begin
        chk("p2_addr", ev_addr, 32'(acc * 4));
        acc++;
      end
    end
    chk("p2_accepts", 32'(acc), 32'(DEPTH));
    chk("p2_req_low", 32'(ev_rv), 32'd0);
    ordy_pct = 100; nout = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 32'h0);
      if (ev_outv) begin
        chk("p2_seq", ev_pc, 32'(nout * 4));
        nout++;
      end
    end

    // L=3 with fetches in flight, redirect to 0x100: stale data never shows.
    lat_lo = 3; lat_hi = 3;
    do_reset();
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    step(1'b1, 32'h100);
    chk("p3_quiet", 32'(ev_outv), 32'd0);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step(1'b0, 32'h0);
      if (ev_outv) begin
        found = 1;
        chk("p3_pc", ev_pc, 32'h100);
      end
    end
    chk("p3_found", 32'(found), 32'd1);

    // Redirect, response and head handshake in one cycle.
    lat_lo = 1; lat_hi = 1;
    do_reset();
    repeat (6) step(1'b0, 32'h0);
    step(1'b1, 32'h200);
    chk("p4_pop", 32'(ev_pop), 32'd1);
    chk("p4_resp", 32'(ev_resp), 32'd1);
    found = 0; lat_n = 0;
    for (int j = 1; j <= 10 && found == 0; j++) begin
      step(1'b0, 32'h0);
      if (ev_outv) begin
        found = 1; lat_n = j;
        chk("p4_pc", ev_pc, 32'h200);
      end
    end
    chk("p4_latency", 32'(lat_n), 32'd3);

    // PC wrap from an unaligned redirect near the top of memory.
    do_reset();
    step(1'b1, 32'hFFFF_FFFE);
    wa[0] = 32'hDEAD_BEEF; wa[1] = 32'hDEAD_BEEF; na = 0;
    for (int j = 0; j < 10 && na < 2; j++) begin
      step(1'b0, 32'h0);
      if (ev_fire) begin
        wa[na] = ev_addr;
        na++;
      end
    end
    chk("p5_addr0", wa[0], 32'hFFFF_FFFC);
    chk("p5_addr1", wa[1], 32'h0000_0000);

    // Predecode of one instruction per immediate format.
    mem_mode = 1;
    do_reset();
    nout = 0;
    for (int k = 0; k < 30 && nout < 6; k++) begin
      step(1'b0, 32'h0);
      if (ev_outv) begin
        chk("p6_sel", 32'(ev_sel), 32'(psel[nout]));
        nout++;
      end
    end
    chk("p6_count", 32'(nout), 32'd6);

    // Randomized traffic, latency and redirects, with a reset midway.
    mem_mode = 2; rdy_pct = 70; ordy_pct = 60; lat_lo = 1; lat_hi = 4;
    do_reset();
    for (int k = 0; k < 1500; k++)
      step($urandom_range(99) < 3, $urandom);
    rdy_pct = 100; ordy_pct = 90; lat_lo = 1; lat_hi = 2;
    do_reset();
    for (int k = 0; k < 1500; k++)
      step($urandom_range(99) < 4, $urandom);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
